mem_access_ctrl: RTL

Clocked memory-bus initiator that drives the CPU side of the MOV/MOC handshake into the 512-byte RAM. It accepts one load/store request at a time from the control unit and issues byte, halfword or word accesses on the RAM bus. It splits doublewords into two word accesses and returns sign- or zero-extended 64-bit load data. It also raises an error for misaligned or out-of-range addresses.

---
 rtl/mem_access_ctrl_if.sv | 30 +++
 rtl/mem_access_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl_if.sv
// RAM-side MOV/MOC bus between the access controller (master) and the 512-byte RAM (slave).
interface mem_access_ctrl_if;
  logic        mov;
  logic        read_write;
  logic [31:0] address;
  logic [31:0] mem_data_in;
  logic [1:0]  datatype;
  logic        moc;
  logic [31:0] mem_data_out;

  modport master (
    output mov,
    output read_write,
    output address,
    output mem_data_in,
    output datatype,
    input  moc,
    input  mem_data_out
  );

  modport slave (
    input  mov,
    input  read_write,
    input  address,
    input  mem_data_in,
    input  datatype,
    output moc,
    output mem_data_out
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access controller: CPU-side initiator of the MOV/MOC handshake to the RAM.
// Takes one load/store at a time, splits doublewords into two big-endian word accesses,
// sign/zero-extends load data and rejects misaligned or out-of-range requests.
// Optional feature: define MEM_TIMEOUT_EN to abort an ACCESS that never sees MOC.
module mem_access_ctrl #(
  parameter int unsigned MEM_BYTES   = 512
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        rw_i,
  input  logic [1:0]  size_i,
  input  logic        signed_ld_i,
  input  logic [31:0] addr_i,
  input  logic [63:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [63:0] rdata_o,
  mem_access_ctrl_if.master mem_if
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  localparam logic [1:0] SizeDword = 2'b11;
  localparam logic [1:0] SizeWord  = 2'b10;

  state_e      state_q, state_d;
  logic        rw_q, rw_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        half_q, half_d;
  logic        err_q, err_d;
  logic [63:0] rdata_q, rdata_d;
  logic [31:0] first_q, first_d;

  // Bus outputs are registered so they stay stable across SETUP and ACCESS.
  logic        read_write_q, read_write_d;
  logic [31:0] address_q, address_d;
  logic [31:0] mem_data_in_q, mem_data_in_d;
  logic [1:0]  datatype_q, datatype_d;

  logic [3:0]  req_bytes;
  logic [32:0] req_end;
  logic        misaligned;
  logic        out_of_range;
  logic        timeout_hit;

  // Extend a 1/2/4-byte RAM read to 64 bits.
  function automatic logic [63:0] load_extend(input logic [1:0]  size,
                                              input logic        sgn,
                                              input logic [31:0] data);
    logic [63:0] res;
    res = '0;
    case (size)
      2'b00:   res = {{56{sgn & data[7]}}, data[7:0]};
      2'b01:   res = {{48{sgn & data[15]}}, data[15:0]};
      default: res = {{32{sgn & data[31]}}, data};
    endcase
    return res;
  endfunction

  // Alignment and range checks on the incoming request.
  always_comb begin
    req_bytes    = 4'd1 << size_i;
    req_end      = {1'b0, addr_i} + 33'(req_bytes);
    out_of_range = req_end > 33'(MEM_BYTES);
    misaligned   = 1'b0;
    case (size_i)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr_i[0];
      2'b10:   misaligned = |addr_i[1:0];
      default: misaligned = |addr_i[2:0];
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  logic [TmoW-1:0] tmo_q, tmo_d;

  // Counts ACCESS cycles without MOC; restarts on every ACCESS entry.
  always_comb begin
    tmo_d       = tmo_q;
    timeout_hit = (state_q == StAccess) && !mem_if.moc &&
                  (tmo_q == TmoW'(TIMEOUT_CYC - 1));
    if (state_q == StSetup) begin
      tmo_d = '0;
    end else if (state_q == StAccess && !mem_if.moc) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state, request latching and load-data capture.
  always_comb begin
    state_d       = state_q;
    rw_d          = rw_q;
    size_d        = size_q;
    signed_d      = signed_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    half_d        = half_q;
    err_d         = err_q;
    rdata_d       = rdata_q;
    first_d       = first_q;
    read_write_d  = read_write_q;
    address_d     = address_q;
    mem_data_in_d = mem_data_in_q;
    datatype_d    = datatype_q;

    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          rw_d     = rw_i;
          size_d   = size_i;
          signed_d = signed_ld_i;
          addr_d   = addr_i;
          wdata_d  = wdata_i;
          half_d   = 1'b0;
          if (misaligned || out_of_range) begin
            // Rejected requests never touch the bus.
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            err_d         = 1'b0;
            read_write_d  = rw_i;
            address_d     = addr_i;
            datatype_d    = (size_i == SizeDword) ? SizeWord : size_i;
            mem_data_in_d = (size_i == SizeDword) ? wdata_i[63:32] : wdata_i[31:0];
            state_d       = StSetup;
          end
        end
      end

      StSetup: begin
        state_d = StAccess;
      end

      StAccess: begin
        if (mem_if.moc) begin
          if (rw_q) begin
            if (size_q == SizeDword) begin
              if (!half_q) begin
                first_d = mem_if.mem_data_out;
              end else begin
                rdata_d = {first_q, mem_if.mem_data_out};
              end
            end else begin
              rdata_d = load_extend(size_q, signed_q, mem_if.mem_data_out);
            end
          end
          if (size_q == SizeDword && !half_q) begin
            // Second word: going back through SETUP drops MOV for a cycle so the RAM
            // re-clears MOC before the next access.
            half_d        = 1'b1;
            address_d     = addr_q + 32'd4;
            mem_data_in_d = wdata_q[31:0];
            state_d       = StSetup;
          end else begin
            state_d = StDone;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      rw_q          <= 1'b0;
      size_q        <= 2'b00;
      signed_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      half_q        <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      first_q       <= '0;
      read_write_q  <= 1'b0;
      address_q     <= '0;
      mem_data_in_q <= '0;
      datatype_q    <= 2'b00;
    end else begin
      state_q       <= state_d;
      rw_q          <= rw_d;
      size_q        <= size_d;
      signed_q      <= signed_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      half_q        <= half_d;
      err_q         <= err_d;
      rdata_q       <= rdata_d;
      first_q       <= first_d;
      read_write_q  <= read_write_d;
      address_q     <= address_d;
      mem_data_in_q <= mem_data_in_d;
      datatype_q    <= datatype_d;
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    busy_o             = (state_q != StIdle);
    done_o             = (state_q == StDone);
    err_o              = (state_q == StDone) && err_q;
    rdata_o            = rdata_q;
    mem_if.mov         = (state_q == StAccess);
    mem_if.read_write  = read_write_q;
    mem_if.address     = address_q;
    mem_if.mem_data_in = mem_data_in_q;
    mem_if.datatype    = datatype_q;
  end

endmodule
